// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Scoreboard and hazard/forwarding unit for the in-order core.
//               Sits beside decode and keeps one entry per post-decode stage
//               (index 0 = exe, 1 = mem, ...) in a shift pipeline. From those
//               entries and the decode fields it derives, combinationally:
//                 - hazard_stall : hold fetch/decode and insert a bubble
//                 - fwd_rs1_sel  : 0 = regfile, k = forward from stage k-1
//                 - fwd_rs2_sel  : as above for source 2
//                 - stage_valid  : valid bit per tracked stage
//               and keeps a saturating count of stall cycles (stall_cnt).
//
// Ports       : clk, reset (sync, active-high)
//               dec_valid, dec_kill, cmiss_stall
//               dec_rs1_addr/oen, dec_rs2_addr/oen
//               dec_wb_addr, dec_rf_wen, dec_is_load, dec_is_csr
//               hazard_stall, fwd_rs1_sel, fwd_rs2_sel, stage_valid, stall_cnt
//
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int STAGES        = 3,
    parameter int ADDR_W        = 5,
    parameter int LOAD_LAT      = 1,
    parameter int FWD_EN        = 1,
    parameter int CSR_SERIALIZE = 1,
    parameter int CNT_W         = 32,
    localparam int SELW         = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic              dec_kill,
    input  logic              cmiss_stall,
    input  logic [ADDR_W-1:0] dec_rs1_addr,
    input  logic              dec_rs1_oen,
    input  logic [ADDR_W-1:0] dec_rs2_addr,
    input  logic              dec_rs2_oen,
    input  logic [ADDR_W-1:0] dec_wb_addr,
    input  logic              dec_rf_wen,
    input  logic              dec_is_load,
    input  logic              dec_is_csr,
    output logic              hazard_stall,
    output logic [SELW-1:0]   fwd_rs1_sel,
    output logic [SELW-1:0]   fwd_rs2_sel,
    output logic [STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int c_NSRC = 2;

    // ------------------------------------------------------------------------
    // Per-stage scoreboard entries
    // ------------------------------------------------------------------------
    logic [STAGES-1:0] r_valid;
    logic [ADDR_W-1:0] r_wb_addr [STAGES];
    logic [STAGES-1:0] r_rf_wen;
    logic [STAGES-1:0] r_is_load;
    logic [STAGES-1:0] r_is_csr;
    logic [CNT_W-1:0]  r_stall_cnt;

    // ------------------------------------------------------------------------
    // Source operand views, indexed 0 = rs1, 1 = rs2
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_src_addr [c_NSRC];
    logic [c_NSRC-1:0] w_src_oen;
    logic [c_NSRC-1:0] w_src_stall;
    logic [SELW-1:0]   w_src_sel  [c_NSRC];

    logic w_csr_stall;
    logic w_accept;

    assign w_src_addr[0] = dec_rs1_addr;
    assign w_src_addr[1] = dec_rs2_addr;
    assign w_src_oen[0]  = dec_rs1_oen;
    assign w_src_oen[1]  = dec_rs2_oen;

    // ------------------------------------------------------------------------
    // RAW detection and forwarding select, one copy per source operand
    // ------------------------------------------------------------------------
    for (genvar gs = 0; gs < c_NSRC; gs++) begin : g_src
        logic [STAGES-1:0] w_match;
        logic              w_hit;
        logic              w_early_load;
        logic [SELW-1:0]   w_idx;

        // x0 is hardwired to zero, so it can never be a real dependency.
        always_comb begin
            w_match = '0;
            for (int i = 0; i < STAGES; i++) begin
                w_match[i] = r_valid[i] & r_rf_wen[i]
                           & (r_wb_addr[i] == w_src_addr[gs])
                           & (w_src_addr[gs] != '0)
                           & w_src_oen[gs];
            end
        end

        // Walk from the oldest stage down so the youngest match (lowest
        // index) is the one left standing. w_early_load flags a load whose
        // data is not yet available for forwarding at that stage.
        always_comb begin
            w_hit        = 1'b0;
            w_early_load = 1'b0;
            w_idx        = '0;
            for (int i = STAGES - 1; i >= 0; i--) begin
                if (w_match[i]) begin
                    w_hit        = 1'b1;
                    w_early_load = r_is_load[i] && (i < LOAD_LAT);
                    w_idx        = SELW'(i);
                end
            end
        end

        if (FWD_EN != 0) begin : g_fwd
            assign w_src_stall[gs] = w_hit & w_early_load;
            assign w_src_sel[gs]   = (w_hit & ~w_early_load) ? (w_idx + SELW'(1))
                                                             : '0;
        end else begin : g_nofwd
            // Without a bypass network every outstanding write must retire
            // before the consumer may read the regfile.
            assign w_src_stall[gs] = |w_match;
            assign w_src_sel[gs]   = '0;
        end
    end

    // ------------------------------------------------------------------------
    // CSR serialisation: nothing issues behind an in-flight CSR op
    // ------------------------------------------------------------------------
    if (CSR_SERIALIZE != 0) begin : g_csr
        assign w_csr_stall = |(r_valid & r_is_csr);
    end else begin : g_nocsr
        assign w_csr_stall = 1'b0;
    end

    // A killed instruction is discarded anyway, so it must never hold decode.
    assign hazard_stall = (|w_src_stall | w_csr_stall) & dec_valid & ~dec_kill;
    assign w_accept     = dec_valid & ~dec_kill & ~hazard_stall;

    assign fwd_rs1_sel = w_src_sel[0];
    assign fwd_rs2_sel = w_src_sel[1];
    assign stage_valid = r_valid;
    assign stall_cnt   = r_stall_cnt;

    // ------------------------------------------------------------------------
    // Shift pipeline and stall counter; everything freezes on cmiss_stall
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= '0;
            r_rf_wen    <= '0;
            r_is_load   <= '0;
            r_is_csr    <= '0;
            r_stall_cnt <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_wb_addr[i] <= '0;
            end
        end else if (!cmiss_stall) begin
            for (int i = 1; i < STAGES; i++) begin
                r_valid[i]   <= r_valid[i-1];
                r_wb_addr[i] <= r_wb_addr[i-1];
                r_rf_wen[i]  <= r_rf_wen[i-1];
                r_is_load[i] <= r_is_load[i-1];
                r_is_csr[i]  <= r_is_csr[i-1];
            end
            // A rejected or absent instruction enters as an all-zero bubble.
            r_valid[0]   <= w_accept;
            r_wb_addr[0] <= w_accept ? dec_wb_addr : '0;
            r_rf_wen[0]  <= w_accept & dec_rf_wen;
            r_is_load[0] <= w_accept & dec_is_load;
            r_is_csr[0]  <= w_accept & dec_is_csr;

            if (hazard_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit. Three instances share the
//               stimulus: the default configuration (scoreboarded against a
//               reference model on every cycle), a no-forwarding variant and
//               a 2-bit counter variant for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid, dec_kill, cmiss_stall;
    logic [4:0] dec_rs1_addr, dec_rs2_addr, dec_wb_addr;
    logic       dec_rs1_oen, dec_rs2_oen, dec_rf_wen, dec_is_load, dec_is_csr;

    logic       stall1, stall2, stall3;
    logic [1:0] s1_1, s2_1, s1_2, s2_2, s1_3, s2_3;
    logic [2:0] sv1, sv2, sv3;
    logic [31:0] cnt1, cnt2;
    logic [1:0]  cnt3;

    always #5 clk = ~clk;

    hazard_unit u_dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_kill(dec_kill),
        .cmiss_stall(cmiss_stall), .dec_rs1_addr(dec_rs1_addr), .dec_rs1_oen(dec_rs1_oen),
        .dec_rs2_addr(dec_rs2_addr), .dec_rs2_oen(dec_rs2_oen), .dec_wb_addr(dec_wb_addr),
        .dec_rf_wen(dec_rf_wen), .dec_is_load(dec_is_load), .dec_is_csr(dec_is_csr),
        .hazard_stall(stall1), .fwd_rs1_sel(s1_1), .fwd_rs2_sel(s2_1),
        .stage_valid(sv1), .stall_cnt(cnt1)
    );

    hazard_unit #(.FWD_EN(0)) u_nofwd (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_kill(dec_kill),
        .cmiss_stall(cmiss_stall), .dec_rs1_addr(dec_rs1_addr), .dec_rs1_oen(dec_rs1_oen),
        .dec_rs2_addr(dec_rs2_addr), .dec_rs2_oen(dec_rs2_oen), .dec_wb_addr(dec_wb_addr),
        .dec_rf_wen(dec_rf_wen), .dec_is_load(dec_is_load), .dec_is_csr(dec_is_csr),
        .hazard_stall(stall2), .fwd_rs1_sel(s1_2), .fwd_rs2_sel(s2_2),
        .stage_valid(sv2), .stall_cnt(cnt2)
    );

    hazard_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_kill(dec_kill),
        .cmiss_stall(cmiss_stall), .dec_rs1_addr(dec_rs1_addr), .dec_rs1_oen(dec_rs1_oen),
        .dec_rs2_addr(dec_rs2_addr), .dec_rs2_oen(dec_rs2_oen), .dec_wb_addr(dec_wb_addr),
        .dec_rf_wen(dec_rf_wen), .dec_is_load(dec_is_load), .dec_is_csr(dec_is_csr),
        .hazard_stall(stall3), .fwd_rs1_sel(s1_3), .fwd_rs2_sel(s2_3),
        .stage_valid(sv3), .stall_cnt(cnt3)
    );

    // ------------------------------------------------------------------------
    // Stimulus record, reference model and scoreboard
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic       v;
        logic       kill;
        logic       cm;
        logic [4:0] rs1;
        logic       oe1;
        logic [4:0] rs2;
        logic       oe2;
        logic [4:0] wb;
        logic       wen;
        logic       ld;
        logic       csr;
    } dec_t;

    typedef struct packed {
        logic       v;
        logic [4:0] a;
        logic       w;
        logic       l;
        logic       c;
    } ment_t;

    typedef struct {
        logic        st;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [2:0]  sv;
        logic [31:0] cnt;
        logic [1:0]  cs;
    } exp_t;

    localparam dec_t IDLE = '0;

    ment_t m [3];
    int    m_cnt;
    exp_t  q [$];
    dec_t  cur;
    logic  cur_rst;
    logic  cur_stall;
    logic  have_prev;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic dec_t op(input logic [4:0] wb, input logic wen, input logic ld,
                                input logic csr, input logic [4:0] rs1, input logic oe1,
                                input logic [4:0] rs2, input logic oe2);
        dec_t d;
        d     = '0;
        d.v   = 1'b1;
        d.wb  = wb;
        d.wen = wen;
        d.ld  = ld;
        d.csr = csr;
        d.rs1 = rs1;
        d.oe1 = oe1;
        d.rs2 = rs2;
        d.oe2 = oe2;
        return d;
    endfunction

    // Youngest matching stage decides: an exe-stage load stalls, anything
    // else forwards from its stage.
    function automatic void m_src(input logic [4:0] a, input logic oe,
                                  output logic st, output logic [1:0] sel);
        st  = 1'b0;
        sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (m[i].v && m[i].w && m[i].a == a && a != 5'd0 && oe) begin
                if (m[i].l && i < 1) st = 1'b1;
                else sel = 2'(i + 1);
                break;
            end
        end
    endfunction

    task automatic model_step();
        if (cur_rst) begin
            for (int i = 0; i < 3; i++) m[i] = '0;
            m_cnt = 0;
        end else if (!cur.cm) begin
            m[2] = m[1];
            m[1] = m[0];
            if (cur.v && !cur.kill && !cur_stall) begin
                m[0].v = 1'b1;
                m[0].a = cur.wb;
                m[0].w = cur.wen;
                m[0].l = cur.ld;
                m[0].c = cur.csr;
            end else begin
                m[0] = '0;
            end
            if (cur_stall) m_cnt++;
        end
    endtask

    // One clock: advance the model past the previous edge, drive new inputs,
    // push the expectation, then pop and compare at the falling edge.
    task automatic cyc(input dec_t d, input logic rst_in);
        exp_t e, o;
        logic st1, st2;
        logic [1:0] a1, a2;
        if (have_prev) begin
            model_step();
            @(posedge clk);
            #1;
        end
        have_prev    = 1'b1;
        cur          = d;
        cur_rst      = rst_in;
        reset        = rst_in;
        dec_valid    = d.v;
        dec_kill     = d.kill;
        cmiss_stall  = d.cm;
        dec_rs1_addr = d.rs1;
        dec_rs1_oen  = d.oe1;
        dec_rs2_addr = d.rs2;
        dec_rs2_oen  = d.oe2;
        dec_wb_addr  = d.wb;
        dec_rf_wen   = d.wen;
        dec_is_load  = d.ld;
        dec_is_csr   = d.csr;

        m_src(d.rs1, d.oe1, st1, a1);
        m_src(d.rs2, d.oe2, st2, a2);
        e.st  = (st1 | st2 | (m[0].v & m[0].c) | (m[1].v & m[1].c) | (m[2].v & m[2].c))
                & d.v & ~d.kill;
        e.s1  = a1;
        e.s2  = a2;
        e.sv  = {m[2].v, m[1].v, m[0].v};
        e.cnt = m_cnt;
        e.cs  = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
        cur_stall = e.st;
        q.push_back(e);

        #4;
        o = q.pop_front();
        chk("sb_stall", stall1, o.st);
        chk("sb_sel1", s1_1, o.s1);
        chk("sb_sel2", s2_1, o.s2);
        chk("sb_valid", sv1, o.sv);
        chk("sb_cnt", cnt1, o.cnt);
        chk("sb_cnt_sat", cnt3, o.cs);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(IDLE, 1'b0);
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios followed by a random run
    // ------------------------------------------------------------------------
    initial begin
        dec_t d;
        have_prev    = 1'b0;
        cur          = '0;
        cur_rst      = 1'b0;
        cur_stall    = 1'b0;
        m_cnt        = 0;
        for (int i = 0; i < 3; i++) m[i] = '0;
        reset        = 1'b1;
        dec_valid    = 1'b0;
        dec_kill     = 1'b0;
        cmiss_stall  = 1'b0;
        dec_rs1_addr = '0;
        dec_rs1_oen  = 1'b0;
        dec_rs2_addr = '0;
        dec_rs2_oen  = 1'b0;
        dec_wb_addr  = '0;
        dec_rf_wen   = 1'b0;
        dec_is_load  = 1'b0;
        dec_is_csr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        cyc(IDLE, 1'b0);
        chk("rst_stall", stall1, 0);
        chk("rst_sel1", s1_1, 0);
        chk("rst_sel2", s2_1, 0);
        chk("rst_valid", sv1, 0);
        chk("rst_cnt", cnt1, 0);

        // Forwarding from exe then mem
        cyc(op(5'd5, 1, 0, 0, 5'd0, 0, 5'd0, 0), 1'b0);
        cyc(op(5'd6, 1, 0, 0, 5'd5, 1, 5'd0, 0), 1'b0);
        chk("fwd_exe_stall", stall1, 0);
        chk("fwd_exe_sel", s1_1, 1);
        cyc(op(5'd0, 0, 0, 0, 5'd5, 1, 5'd0, 0), 1'b0);
        chk("fwd_mem_sel", s1_1, 2);
        drain(3);

        // Load-use: one stall cycle, then forward from mem
        cyc(op(5'd7, 1, 1, 0, 5'd0, 0, 5'd0, 0), 1'b0);
        cyc(op(5'd0, 0, 0, 0, 5'd0, 0, 5'd7, 1), 1'b0);
        chk("lu_stall", stall1, 1);
        cyc(op(5'd0, 0, 0, 0, 5'd0, 0, 5'd7, 1), 1'b0);
        chk("lu_release", stall1, 0);
        chk("lu_sel2", s2_1, 2);
        chk("lu_cnt", cnt1, 1);
        drain(3);

        // x0 never matches; youngest of two writers wins
        cyc(op(5'd0, 1, 0, 0, 5'd0, 0, 5'd0, 0), 1'b0);
        cyc(op(5'd3, 1, 0, 0, 5'd0, 1, 5'd0, 0), 1'b0);
        chk("x0_stall", stall1, 0);
        chk("x0_sel", s1_1, 0);
        cyc(op(5'd3, 1, 0, 0, 5'd0, 0, 5'd0, 0), 1'b0);
        cyc(op(5'd0, 0, 0, 0, 5'd3, 1, 5'd0, 0), 1'b0);
        chk("prio_sel", s1_1, 1);
        drain(3);

        // Freeze during a load-use stall
        cyc(op(5'd7, 1, 1, 0, 5'd0, 0, 5'd0, 0), 1'b0);
        d = op(5'd0, 0, 0, 0, 5'd0, 0, 5'd7, 1);
        d.cm = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(d, 1'b0);
            chk("frz_stall", stall1, 1);
            chk("frz_valid", sv1, 3'b001);
            chk("frz_cnt", cnt1, 1);
        end
        d.cm = 1'b0;
        cyc(d, 1'b0);
        chk("frz_rel_stall", stall1, 1);
        cyc(d, 1'b0);
        chk("frz_done_stall", stall1, 0);
        chk("frz_done_sel", s2_1, 2);
        chk("frz_done_valid", sv1, 3'b010);
        chk("frz_done_cnt", cnt1, 2);
        drain(3);

        // Kill beats a load-use hazard
        cyc(op(5'd7, 1, 1, 0, 5'd0, 0, 5'd0, 0), 1'b0);
        d = op(5'd0, 0, 0, 0, 5'd0, 0, 5'd7, 1);
        d.kill = 1'b1;
        cyc(d, 1'b0);
        chk("kill_stall", stall1, 0);
        cyc(IDLE, 1'b0);
        chk("kill_bubble", sv1, 3'b010);
        drain(2);

        // CSR serialises for the full depth of the pipe
        cyc(op(5'd0, 0, 0, 1, 5'd0, 0, 5'd0, 0), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(op(5'd0, 0, 0, 0, 5'd0, 0, 5'd0, 0), 1'b0);
            chk("csr_stall", stall1, 1);
        end
        cyc(op(5'd0, 0, 0, 0, 5'd0, 0, 5'd0, 0), 1'b0);
        chk("csr_release", stall1, 0);
        chk("csr_cnt", cnt1, 5);
        chk("sat_cnt", cnt3, 3);
        drain(3);

        // No-forwarding instance: stall until the writer leaves the pipe
        cyc(IDLE, 1'b1);
        cyc(op(5'd9, 1, 0, 0, 5'd0, 0, 5'd0, 0), 1'b0);
        chk("nf_rst_valid", sv2, 0);
        chk("nf_rst_cnt", cnt2, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(op(5'd0, 0, 0, 0, 5'd9, 1, 5'd0, 0), 1'b0);
            chk("nf_stall", stall2, 1);
            chk("nf_sel1", s1_2, 0);
        end
        cyc(op(5'd0, 0, 0, 0, 5'd9, 1, 5'd0, 0), 1'b0);
        chk("nf_release", stall2, 0);
        chk("nf_cnt", cnt2, 3);

        // Reset in the middle of a stall
        cyc(op(5'd9, 1, 0, 0, 5'd0, 0, 5'd0, 0), 1'b0);
        cyc(op(5'd0, 0, 0, 0, 5'd9, 1, 5'd0, 0), 1'b0);
        chk("nf_mid_stall", stall2, 1);
        cyc(op(5'd0, 0, 0, 0, 5'd9, 1, 5'd0, 0), 1'b1);
        cyc(op(5'd0, 0, 0, 0, 5'd9, 1, 5'd0, 0), 1'b0);
        chk("nf_postrst_stall", stall2, 0);
        chk("nf_postrst_cnt", cnt2, 0);
        chk("postrst_cnt", cnt1, 0);
        drain(3);

        // Random traffic on a small register window to provoke many hazards
        for (int n = 0; n < 400; n++) begin
            d      = '0;
            d.v    = ($urandom_range(0, 3) != 0);
            d.kill = ($urandom_range(0, 7) == 0);
            d.cm   = ($urandom_range(0, 5) == 0);
            d.rs1  = 5'($urandom_range(0, 3));
            d.oe1  = ($urandom_range(0, 3) != 0);
            d.rs2  = 5'($urandom_range(0, 3));
            d.oe2  = ($urandom_range(0, 3) != 0);
            d.wb   = 5'($urandom_range(0, 3));
            d.wen  = ($urandom_range(0, 3) != 0);
            d.ld   = ($urandom_range(0, 2) == 0);
            d.csr  = ($urandom_range(0, 19) == 0);
            cyc(d, ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
